// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared memory port: grants one burst requester at a
// time, issues its beats with incrementing addresses and tags returning read data.
module mem_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic                      mem_stall,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        beat,
    output logic [NUM_REQ-1:0]        done,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      rvalid,
    output logic [ID_W-1:0]           rid,
    output logic [DATA_W-1:0]         rdata
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    state_t              state_r, state_nxt_s;
    logic [ID_W-1:0]     last_r, id_r, sel_s, idx_s, rid_r;
    logic [ADDR_W-1:0]   base_r;
    logic [LEN_W-1:0]    len_r, cnt_r;
    logic                we_r, rvalid_r, sel_found_s, capture_s, advance_s;
    logic [NUM_REQ-1:0]  grant_s, beat_s, done_s;
    logic                mem_en_s, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;

    logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
    logic [LEN_W-1:0]    len_a   [NUM_REQ];
    logic [DATA_W-1:0]   wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign len_a[g]   = req_len[g*LEN_W +: LEN_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // Round-robin pick: first valid requester after last_r, wrapping; last_r itself scanned last.
    always_comb begin
        sel_s       = '0;
        idx_s       = '0;
        sel_found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_W'((int'(last_r) + k) % NUM_REQ);
            if (!sel_found_s && req_valid[idx_s]) begin
                sel_found_s = 1'b1;
                sel_s       = idx_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next state and port strobes; nothing is driven while reset is held.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = '0;
        beat_s      = '0;
        done_s      = '0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        capture_s   = 1'b0;
        advance_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rst && sel_found_s) begin
                    capture_s      = 1'b1;
                    grant_s[sel_s] = 1'b1;
                    if (len_a[sel_s] == {LEN_W{1'b0}}) begin
                        done_s[sel_s] = 1'b1;
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        state_nxt_s   = ST_BURST;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!rst && !mem_stall) begin
                    advance_s     = 1'b1;
                    mem_en_s      = 1'b1;
                    mem_we_s      = we_r;
                    mem_addr_s    = base_r + ADDR_W'(cnt_r);
                    mem_wdata_s   = wdata_a[id_r];
                    beat_s[id_r]  = 1'b1;
                    if (cnt_r == len_r - LEN_W'(1)) begin
                        done_s[id_r] = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s  = ST_BURST;
                    end
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Captured burst parameters, beat counter and read-return tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r   <= ID_W'(NUM_REQ - 1);
            id_r     <= '0;
            base_r   <= '0;
            len_r    <= '0;
            we_r     <= 1'b0;
            cnt_r    <= '0;
            rvalid_r <= 1'b0;
            rid_r    <= '0;
        end else begin
            if (capture_s) begin
                last_r <= sel_s;
                id_r   <= sel_s;
                base_r <= addr_a[sel_s];
                len_r  <= len_a[sel_s];
                we_r   <= req_we[sel_s];
                cnt_r  <= '0;
            end else if (advance_s) begin
                cnt_r  <= cnt_r + LEN_W'(1);
            end else begin
                cnt_r  <= cnt_r;
            end
            rvalid_r <= mem_en_s & ~mem_we_s;
            rid_r    <= id_r;
        end
    end

    assign grant     = grant_s;
    assign beat      = beat_s;
    assign done      = done_s;
    assign mem_en    = mem_en_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign rvalid    = rvalid_r;
    assign rid       = rid_r;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int LW = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid, req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR*DW-1:0]  req_wdata;
    logic              mem_stall;
    logic [DW-1:0]     mem_rdata;
    logic [NR-1:0]     grant, beat, done;
    logic              mem_en, mem_we, rvalid;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, rdata;
    logic [IW-1:0]     rid;

    mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .grant(grant), .beat(beat),
        .done(done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rvalid(rvalid), .rid(rid), .rdata(rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: busy flag, owner, running address and beats remaining.
    bit            m_busy, m_we, m_rvalid, e_found, e_en, e_we;
    int            m_owner, m_naddr, m_left, m_last, m_rid, e_sel;
    logic [NR-1:0] e_grant, e_beat, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    function automatic int len_of(input int i);
        return int'(req_len[i*LW +: LW]);
    endfunction

    task automatic model_eval();
        e_grant = '0; e_beat = '0; e_done = '0; e_en = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0; e_found = 1'b0; e_sel = 0;
        if (rst) return;
        if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (!e_found && req_valid[c]) begin
                    e_found = 1'b1;
                    e_sel = c;
                end
            end
            if (e_found) begin
                e_grant[e_sel] = 1'b1;
                if (len_of(e_sel) == 0) e_done[e_sel] = 1'b1;
            end
        end else if (!mem_stall) begin
            e_en = 1'b1;
            e_we = m_we;
            e_addr = AW'(m_naddr);
            e_wdata = req_wdata[m_owner*DW +: DW];
            e_beat[m_owner] = 1'b1;
            if (m_left == 1) e_done[m_owner] = 1'b1;
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            m_busy = 1'b0; m_last = NR - 1; m_rvalid = 1'b0; m_rid = 0;
            return;
        end
        m_rvalid = e_en && !e_we;
        m_rid = m_owner;
        if (!m_busy) begin
            if (e_found) begin
                m_last = e_sel;
                if (len_of(e_sel) > 0) begin
                    m_busy = 1'b1;
                    m_owner = e_sel;
                    m_naddr = int'(req_addr[e_sel*AW +: AW]);
                    m_left = len_of(e_sel);
                    m_we = req_we[e_sel];
                end
            end
        end else if (e_en) begin
            m_naddr = (m_naddr + 1) % 4096;
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
    endtask

    logic [NR-1:0] o_grant, o_beat, o_done;
    logic          o_en, o_rvalid;
    logic [AW-1:0] o_addr;
    logic [IW-1:0] o_rid;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] wd_q[$];
    int n_rv, n_done, n_done_beat;

    task automatic clear_logs();
        addr_q.delete(); wd_q.delete();
        n_rv = 0; n_done = 0; n_done_beat = 0;
    endtask

    // One clock: sample and check at negedge, advance the model at posedge.
    task automatic tick();
        mem_rdata = DW'($urandom);
        @(negedge clk);
        model_eval();
        o_grant = grant; o_beat = beat; o_done = done; o_en = mem_en;
        o_addr = mem_addr; o_rvalid = rvalid; o_rid = rid;
        if (!rst) begin
            chk("grant", 64'(grant), 64'(e_grant));
            chk("beat", 64'(beat), 64'(e_beat));
            chk("done", 64'(done), 64'(e_done));
            chk("mem_en", 64'(mem_en), 64'(e_en));
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            chk("rvalid", 64'(rvalid), 64'(m_rvalid));
            if (m_rvalid) chk("rid", 64'(rid), 64'(m_rid));
            chk("rdata", 64'(rdata), 64'(mem_rdata));
            if (mem_en) begin
                addr_q.push_back(mem_addr);
                wd_q.push_back(mem_wdata);
            end
            if (rvalid) n_rv++;
            if (done != '0) n_done++;
            if (done != '0 && mem_en) n_done_beat++;
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic [LW-1:0] len;
        logic [NR-1:0] grant, beat, done;
        logic          en;
        logic [AW-1:0] addr;
        logic          rvalid;
        logic [IW-1:0] rid;
    } vec_t;

    vec_t tbl[15];
    logic [63:0] r64;
    logic [NR-1:0] pend;

    initial begin
        // valid, len, grant, beat, done, en, addr, rvalid, rid
        tbl[0]  = '{3'b000, 4'd2, 3'b000, 3'b000, 3'b000, 1'b0, 12'h000, 1'b0, 2'd0};
        tbl[1]  = '{3'b111, 4'd2, 3'b001, 3'b000, 3'b000, 1'b0, 12'h000, 1'b0, 2'd0};
        tbl[2]  = '{3'b110, 4'd2, 3'b000, 3'b001, 3'b000, 1'b1, 12'h100, 1'b0, 2'd0};
        tbl[3]  = '{3'b110, 4'd2, 3'b000, 3'b001, 3'b001, 1'b1, 12'h101, 1'b1, 2'd0};
        tbl[4]  = '{3'b110, 4'd2, 3'b010, 3'b000, 3'b000, 1'b0, 12'h000, 1'b1, 2'd0};
        tbl[5]  = '{3'b100, 4'd2, 3'b000, 3'b010, 3'b000, 1'b1, 12'h200, 1'b0, 2'd0};
        tbl[6]  = '{3'b100, 4'd2, 3'b000, 3'b010, 3'b010, 1'b1, 12'h201, 1'b1, 2'd1};
        tbl[7]  = '{3'b100, 4'd2, 3'b100, 3'b000, 3'b000, 1'b0, 12'h000, 1'b1, 2'd1};
        tbl[8]  = '{3'b001, 4'd2, 3'b000, 3'b100, 3'b000, 1'b1, 12'h300, 1'b0, 2'd0};
        tbl[9]  = '{3'b001, 4'd2, 3'b000, 3'b100, 3'b100, 1'b1, 12'h301, 1'b1, 2'd2};
        tbl[10] = '{3'b011, 4'd0, 3'b001, 3'b000, 3'b001, 1'b0, 12'h000, 1'b1, 2'd2};
        tbl[11] = '{3'b010, 4'd1, 3'b010, 3'b000, 3'b000, 1'b0, 12'h000, 1'b0, 2'd0};
        tbl[12] = '{3'b000, 4'd1, 3'b000, 3'b010, 3'b010, 1'b1, 12'h200, 1'b0, 2'd0};
        tbl[13] = '{3'b000, 4'd1, 3'b000, 3'b000, 3'b000, 1'b0, 12'h000, 1'b1, 2'd1};
        tbl[14] = '{3'b000, 4'd1, 3'b000, 3'b000, 3'b000, 1'b0, 12'h000, 1'b0, 2'd0};

        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
        req_wdata = '0; mem_stall = 1'b0; mem_rdata = '0;
        m_busy = 1'b0; m_we = 1'b0; m_rvalid = 1'b0; m_owner = 0; m_naddr = 0;
        m_left = 0; m_last = NR - 1; m_rid = 0;
        clear_logs();
        tick();
        tick();
        rst = 1'b0;

        req_addr = {12'h300, 12'h200, 12'h100};
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].valid;
            req_len = {NR{tbl[i].len}};
            tick();
            chk($sformatf("tbl%0d_grant", i), 64'(o_grant), 64'(tbl[i].grant));
            chk($sformatf("tbl%0d_beat", i), 64'(o_beat), 64'(tbl[i].beat));
            chk($sformatf("tbl%0d_done", i), 64'(o_done), 64'(tbl[i].done));
            chk($sformatf("tbl%0d_en", i), 64'(o_en), 64'(tbl[i].en));
            chk($sformatf("tbl%0d_addr", i), 64'(o_addr), 64'(tbl[i].addr));
            chk($sformatf("tbl%0d_rvalid", i), 64'(o_rvalid), 64'(tbl[i].rvalid));
            if (tbl[i].rvalid) chk($sformatf("tbl%0d_rid", i), 64'(o_rid), 64'(tbl[i].rid));
        end

        // Requester 1 read with a stall on the second beat cycle.
        clear_logs();
        req_addr[1*AW +: AW] = 12'h010; req_len[1*LW +: LW] = 4'd4; req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        tick();
        mem_stall = 1'b1;
        tick();
        mem_stall = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_nbeats", 64'(addr_q.size()), 64'd4);
        for (int i = 0; i < addr_q.size() && i < 4; i++)
            chk($sformatf("stall_addr%0d", i), 64'(addr_q[i]), 64'(12'h010 + i));
        chk("stall_ndone", 64'(n_done), 64'd1);
        chk("stall_done_on_beat", 64'(n_done_beat), 64'd1);

        // Requester 2 write crossing the top of the address space.
        clear_logs();
        req_we = 3'b100; req_addr[2*AW +: AW] = 12'hFFE; req_len[2*LW +: LW] = 4'd3;
        req_wdata[2*DW +: DW] = 16'hA000; req_valid = 3'b100;
        tick();
        req_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_beat[2]) req_wdata[2*DW +: DW] = req_wdata[2*DW +: DW] + 16'd1;
        end
        tick();
        tick();
        chk("wrap_nbeats", 64'(addr_q.size()), 64'd3);
        if (addr_q.size() == 3) begin
            chk("wrap_addr0", 64'(addr_q[0]), 64'h0FFE);
            chk("wrap_addr1", 64'(addr_q[1]), 64'h0FFF);
            chk("wrap_addr2", 64'(addr_q[2]), 64'h0000);
            chk("wrap_wd0", 64'(wd_q[0]), 64'hA000);
            chk("wrap_wd1", 64'(wd_q[1]), 64'hA001);
            chk("wrap_wd2", 64'(wd_q[2]), 64'hA002);
        end
        chk("wrap_no_rvalid", 64'(n_rv), 64'd0);
        req_we = 3'b000;

        // Reset during beat 2 of a 5-beat read from requester 0.
        req_len = {4'd2, 4'd2, 4'd5}; req_addr[0 +: AW] = 12'h040; req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_beat", 64'(o_beat), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_en", 64'(o_en), 64'd0);
        chk("rst_rvalid", 64'(o_rvalid), 64'd0);
        req_valid = 3'b011;
        tick();
        chk("rst_prio_grant", 64'(o_grant), 64'b001);
        req_valid = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick();
            req_valid = req_valid & ~e_grant;
        end

        // Owner rewrites its request fields mid-burst.
        clear_logs();
        req_addr[1*AW +: AW] = 12'h0A0; req_len[1*LW +: LW] = 4'd3; req_valid = 3'b010;
        tick();
        req_valid = 3'b000; req_addr[1*AW +: AW] = 12'h555; req_len[1*LW +: LW] = 4'd9;
        for (int i = 0; i < 5; i++) tick();
        chk("capt_nbeats", 64'(addr_q.size()), 64'd3);
        for (int i = 0; i < addr_q.size() && i < 3; i++)
            chk($sformatf("capt_addr%0d", i), 64'(addr_q[i]), 64'(12'h0A0 + i));
        chk("capt_ndone", 64'(n_done), 64'd1);

        // Randomized traffic against the model.
        pend = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(3, 0) == 0) begin
                    pend[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_len[i*LW +: LW] = ($urandom_range(3, 0) == 0) ? 4'd0 : LW'($urandom_range(15, 1));
                    req_we[i] = 1'($urandom_range(1, 0));
                end
            end
            req_valid = pend;
            mem_stall = ($urandom_range(3, 0) == 0);
            r64 = {$urandom, $urandom};
            req_wdata = r64[NR*DW-1:0];
            rst = ($urandom_range(299, 0) == 0);
            tick();
            pend = pend & ~e_grant;
        end
        rst = 1'b0; req_valid = '0; mem_stall = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
